// File: rtl/adpll_pgm_sequencer_if.sv
// Host write port of the ADPLL programming sequencer.
// Carries one select/value write per valid/ready handshake.
interface adpll_pgm_sequencer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_sel;
  logic [4:0] wr_data;

  modport master (
    output wr_valid,
    output wr_sel,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_sel,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/adpll_pgm_sequencer.sv
// ADPLL programming sequencer: replays host writes as SETUP/STROBE/HOLD.
// Optional readback shadow registers: define ADPLL_PGM_SHADOW_EN.
module adpll_pgm_sequencer #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned CNT_W     = 4
) (
  input  logic       clk,
  input  logic       clr,
  adpll_pgm_sequencer_if.slave wr,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       program_o,
  output logic [2:0] param_sel,
  output logic [4:0] pgm_value,
  output logic       pgm_oe
`ifdef ADPLL_PGM_SHADOW_EN
  ,
  input  logic [2:0] rd_sel,
  output logic [4:0] rd_data
`endif
);

  localparam int unsigned SETUP_N = (SETUP_CYC == 0) ? 1 : SETUP_CYC;
  localparam int unsigned PULSE_N = (PULSE_CYC == 0) ? 1 : PULSE_CYC;
  localparam int unsigned HOLD_N  = (HOLD_CYC  == 0) ? 1 : HOLD_CYC;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_N - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_N - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_N - 1);

  localparam logic [2:0] SEL_MAX = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prog_q, prog_d;
  logic [2:0]       sel_q, sel_d;
  logic [4:0]       val_q, val_d;
  logic             oe_q, oe_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             accept;
  logic             cnt_zero;
  logic             hold_exit;

  assign accept   = wr.wr_valid & rdy_q;
  assign cnt_zero = (cnt_q == '0);

  // Next-state and registered-output decode of the phase sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prog_d    = prog_q;
    sel_d     = sel_q;
    val_d     = val_q;
    oe_d      = oe_q;
    rdy_d     = rdy_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    hold_exit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (wr.wr_sel > SEL_MAX) begin
            err_d = 1'b1;
          end else begin
            state_d = SETUP;
            cnt_d   = SETUP_LD;
            sel_d   = wr.wr_sel;
            val_d   = wr.wr_data;
            oe_d    = 1'b1;
            rdy_d   = 1'b0;
            busy_d  = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          state_d = STROBE;
          cnt_d   = PULSE_LD;
          prog_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STROBE: begin
        if (cnt_zero) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
          prog_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          hold_exit = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
          oe_d      = 1'b0;
          rdy_d     = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        prog_d  = 1'b0;
        oe_d    = 1'b0;
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; clr drops the pins at once.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prog_q  <= 1'b0;
      sel_q   <= '0;
      val_q   <= '0;
      oe_q    <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prog_q  <= prog_d;
      sel_q   <= sel_d;
      val_q   <= val_d;
      oe_q    <= oe_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign wr.wr_ready = rdy_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign program_o   = prog_q;
  assign param_sel   = sel_q;
  assign pgm_value   = val_q;
  assign pgm_oe      = oe_q;

`ifdef ADPLL_PGM_SHADOW_EN
  logic [4:0] shadow_q [6];

  // Shadow copy of each parameter, committed when its write completes.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < 6; i++) shadow_q[i] <= '0;
    end else if (hold_exit) begin
      for (int i = 0; i < 6; i++) begin
        if (sel_q == 3'(i)) shadow_q[i] <= val_q;
      end
    end
  end

  // Readback mux; unused selects read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < 6; i++) begin
      if (rd_sel == 3'(i)) rd_data = shadow_q[i];
    end
  end
`endif

endmodule
